// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state codes,
// opcode/funct codes, datapath select encodings and the decoded
// instruction-class and control-bundle structs.
package multi_cycle_ctrl_pkg;

  // Sequencer states; the numeric codes are visible on state_o.
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  // Next-PC select.
  localparam logic [1:0] NPC_PC4    = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_REG    = 2'd3;

  // GRF destination select.
  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  // GRF write-data select.
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC  = 2'd2;

  // Immediate extender mode.
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // ALU operation.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;

  // One-hot instruction class produced by the decoder.
  typedef struct packed {
    logic rcalc;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic illegal;
  } iclass_t;

  // Every datapath control driven by the sequencer, as one bundle.
  typedef struct packed {
    logic       pc_we;
    logic [1:0] npc_sel;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [2:0] alu_op;
    logic       mem_re;
    logic       mem_we;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct held in IR to a
// one-hot class. Anything not in the supported set is flagged illegal,
// including R-type with an unknown funct.
module multi_cycle_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    cls,
  output logic       is_subu
);

  // Classify the instruction; exactly one class bit is set.
  always_comb begin
    cls     = '0;
    is_subu = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.rcalc = 1'b1;
          FN_SUBU: begin
            cls.rcalc = 1'b1;
            is_subu   = 1'b1;
          end
          FN_JR:   cls.jr = 1'b1;
          default: cls.illegal = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore-style sequencer for the multi-cycle MIPS datapath. Steps each
// instruction through IF/ID/EXE/MEM/WB, drives all write enables and mux
// selects per state, inserts MEM_LAT data-memory wait cycles and counts
// retired instructions (illegal ones included).
//
// Handshake: there is no valid/ready pair. The datapath acts on the
// enables in the cycle they are high; select outputs hold their per-state
// value for the entire state so muxes stay stable across it.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pc_we,
  output logic [1:0]  npc_sel,
  output logic        ir_we,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic        alu_src,
  output logic [1:0]  ext_op,
  output logic [2:0]  alu_op,
  output logic        mem_re,
  output logic        mem_we,
  output logic        illegal,
  output logic [2:0]  state_o,
  output logic [31:0] instr_retired
);

  state_t      state;
  state_t      state_next;
  iclass_t     cls;
  logic        is_subu;
  logic [3:0]  wait_cnt;
  logic [31:0] retired_cnt;
  logic        retire;
  logic        mem_enter;
  ctrl_t       c;
  ctrl_t       c_out;

  multi_cycle_ctrl_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .is_subu (is_subu)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IF;
    else       state <= state_next;
  end

  // MEM wait counter: loaded on entry to MEM, counts down while held there.
  always_ff @(posedge clk) begin
    if (reset)                            wait_cnt <= 4'd0;
    else if (mem_enter)                   wait_cnt <= 4'(MEM_LAT);
    else if (state == S_MEM && wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
  end

  // Retired-instruction counter; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)       retired_cnt <= 32'd0;
    else if (retire) retired_cnt <= retired_cnt + 32'd1;
  end

  // Next-state, per-state controls and the retire strobe.
  always_comb begin
    c          = '0;
    state_next = state;
    retire     = 1'b0;
    mem_enter  = 1'b0;
    case (state)
      S_IF: begin
        c.ir_we    = 1'b1;
        c.pc_we    = 1'b1;
        c.npc_sel  = NPC_PC4;
        state_next = S_ID;
      end
      S_ID: begin
        if (cls.j) begin
          c.pc_we    = 1'b1;
          c.npc_sel  = NPC_JUMP;
          state_next = S_IF;
          retire     = 1'b1;
        end else if (cls.jal) begin
          c.pc_we    = 1'b1;
          c.npc_sel  = NPC_JUMP;
          c.reg_we   = 1'b1;
          c.reg_dst  = REGDST_RA;
          c.wd_sel   = WD_PC;
          state_next = S_IF;
          retire     = 1'b1;
        end else if (cls.jr) begin
          c.pc_we    = 1'b1;
          c.npc_sel  = NPC_REG;
          state_next = S_IF;
          retire     = 1'b1;
        end else if (cls.illegal) begin
          // Unsupported: flag it, write nothing, fetch the next one.
          c.illegal  = 1'b1;
          state_next = S_IF;
          retire     = 1'b1;
        end else begin
          state_next = S_EXE;
        end
      end
      S_EXE: begin
        if (cls.rcalc) begin
          c.alu_src  = 1'b0;
          c.alu_op   = is_subu ? ALU_SUB : ALU_ADD;
          state_next = S_WB;
        end else if (cls.ori) begin
          c.ext_op   = EXT_ZERO;
          c.alu_src  = 1'b1;
          c.alu_op   = ALU_OR;
          state_next = S_WB;
        end else if (cls.lui) begin
          // rs is $0 for lui, so OR-ing passes the shifted immediate through.
          c.ext_op   = EXT_LUI;
          c.alu_src  = 1'b1;
          c.alu_op   = ALU_OR;
          state_next = S_WB;
        end else if (cls.lw || cls.sw) begin
          c.ext_op   = EXT_SIGN;
          c.alu_src  = 1'b1;
          c.alu_op   = ALU_ADD;
          state_next = S_MEM;
          mem_enter  = 1'b1;
        end else if (cls.beq) begin
          c.alu_op   = ALU_SUB;
          c.pc_we    = zero;
          c.npc_sel  = NPC_BRANCH;
          state_next = S_IF;
          retire     = 1'b1;
        end else begin
          state_next = S_IF;
        end
      end
      S_MEM: begin
        if (cls.lw) begin
          c.mem_re = 1'b1;
          if (wait_cnt == 4'd0) state_next = S_WB;
        end else if (cls.sw) begin
          // Store commits once, in the last MEM cycle.
          if (wait_cnt == 4'd0) begin
            c.mem_we   = 1'b1;
            state_next = S_IF;
            retire     = 1'b1;
          end
        end else begin
          state_next = S_IF;
        end
      end
      S_WB: begin
        c.reg_we = 1'b1;
        if (cls.rcalc) begin
          c.reg_dst = REGDST_RD;
          c.wd_sel  = WD_ALU;
        end else if (cls.lw) begin
          c.reg_dst = REGDST_RT;
          c.wd_sel  = WD_DM;
        end else begin
          c.reg_dst = REGDST_RT;
          c.wd_sel  = WD_ALU;
        end
        state_next = S_IF;
        retire     = 1'b1;
      end
      default: state_next = S_IF;
    endcase
  end

  // Reset forces every control and debug output low.
  always_comb begin
    c_out = reset ? '0 : c;
  end

  assign pc_we         = c_out.pc_we;
  assign npc_sel       = c_out.npc_sel;
  assign ir_we         = c_out.ir_we;
  assign reg_we        = c_out.reg_we;
  assign reg_dst       = c_out.reg_dst;
  assign wd_sel        = c_out.wd_sel;
  assign alu_src       = c_out.alu_src;
  assign ext_op        = c_out.ext_op;
  assign alu_op        = c_out.alu_op;
  assign mem_re        = c_out.mem_re;
  assign mem_we        = c_out.mem_we;
  assign illegal       = c_out.illegal;
  assign state_o       = reset ? 3'd0 : state;
  assign instr_retired = reset ? 32'd0 : retired_cnt;

endmodule
